// File: rtl/pdp8_pkg.sv
// pdp8_pkg: execution-unit states, opcodes, OPR microinstruction bit positions and dispatch helper
package pdp8_pkg;
  typedef logic [3:0] exec_state_e;
  localparam exec_state_e S_IDLE    = 4'd0;
  localparam exec_state_e S_READY   = 4'd1;
  localparam exec_state_e S_DECODE  = 4'd2;
  localparam exec_state_e S_IND_RD  = 4'd3;
  localparam exec_state_e S_IND_WB  = 4'd4;
  localparam exec_state_e S_OPR_RD  = 4'd5;
  localparam exec_state_e S_EXEC    = 4'd6;
  localparam exec_state_e S_WR_REQ  = 4'd7;
  // group-1 steps sit on a multiple of four so state[1:0] is the step number
  localparam exec_state_e S_G1_S1   = 4'd8;
  localparam exec_state_e S_G1_S2   = 4'd9;
  localparam exec_state_e S_G1_S3   = 4'd10;
  localparam exec_state_e S_G1_S4   = 4'd11;
  localparam exec_state_e S_G2      = 4'd12;
  localparam exec_state_e S_WR_WAIT = 4'd13;
  localparam exec_state_e S_DONE    = 4'd14;
  localparam exec_state_e S_HALT    = 4'd15;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;
  localparam int B_CLA   = 7;
  localparam int B_CLL   = 6;
  localparam int B_CMA   = 5;
  localparam int B_CML   = 4;
  localparam int B_RAR   = 3;
  localparam int B_RAL   = 2;
  localparam int B_TWICE = 1;
  localparam int B_IAC   = 0;
  localparam int B_SMA   = 6;
  localparam int B_SZA   = 5;
  localparam int B_SNL   = 4;
  localparam int B_INV   = 3;
  localparam int B_OSR   = 2;
  localparam int B_HLT   = 1;
  // where a memory-reference instruction goes once its final address is known
  function automatic exec_state_e route(input logic [2:0] o);
    return o == OP_JMP ? S_DONE : (o == OP_DCA || o == OP_JMS) ? S_WR_REQ : S_OPR_RD;
  endfunction
endpackage

// File: rtl/pdp8_opr_alu.sv
// pdp8_opr_alu: combinational OPR evaluation, one group-1 step (step 0..3) or the whole group-2 operation
//   ac, l, mb (low 8 instruction bits), sr -> ac_nxt, l_nxt, skip (group-2 skip condition)
module pdp8_opr_alu
  import pdp8_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic [DW-1:0] ac,
  input  logic          l,
  input  logic [7:0]    mb,
  input  logic [DW-1:0] sr,
  input  logic [1:0]    step,
  input  logic          g2,
  output logic [DW-1:0] ac_nxt,
  output logic          l_nxt,
  output logic          skip
);
  logic [DW:0] la, inc, r1, r2, rot, g1;
  always_comb begin
    la = {l, ac};
    inc = {1'b0, ac} + (DW+1)'(1);
    r1 = mb[B_RAR] ? {la[0], la[DW:1]} : {la[DW-1:0], la[DW]};
    r2 = mb[B_RAR] ? {r1[0], r1[DW:1]} : {r1[DW-1:0], r1[DW]};
    rot = (mb[B_RAR] | mb[B_RAL]) ? (mb[B_TWICE] ? r2 : r1) : la;
    g1 = step == 2'd0 ? {mb[B_CLL] ? 1'b0 : l, mb[B_CLA] ? {DW{1'b0}} : ac} :
         step == 2'd1 ? {l ^ mb[B_CML], mb[B_CMA] ? ~ac : ac} :
         step == 2'd2 ? (mb[B_IAC] ? {l ^ inc[DW], inc[DW-1:0]} : la) : rot;
    skip = ((mb[B_SMA] & ac[DW-1]) | (mb[B_SZA] & ~|ac) | (mb[B_SNL] & l)) ^ mb[B_INV];
    {l_nxt, ac_nxt} = g2 ? {l, (mb[B_CLA] ? {DW{1'b0}} : ac) | (mb[B_OSR] ? sr : {DW{1'b0}})} : g1;
  end
endmodule

// File: rtl/pdp8_exec_unit_p.sv
// pdp8_exec_unit_p: PDP-8 execution unit, memory-reference set plus OPR group 1/2, variable-latency memory
//   in : clk, reset_n (sync, active low), base_addr, instr_valid/instr, sr, exec_rd_valid/exec_rd_data, exec_wr_ack
//   out: stall, PC_value, acc, link, halted, mem_err, exec_rd_req/addr, exec_wr_req/addr/data
//   PDP8_AUTOINC_EN: indirection through 0010..0017 writes the pointer back incremented and uses it
module pdp8_exec_unit_p
  import pdp8_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0] sr,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  link,
  output logic                  halted,
  output logic                  mem_err,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic                  exec_rd_valid,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data,
  input  logic                  exec_wr_ack
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  exec_state_e st;
  logic [DW-1:0] ir, wdata, ac_w, alu_ac;
  logic [AW-1:0] pc_w, ea, ea_dir, pc_fin;
  logic [DW:0] tad_sum;
  logic [2:0] op;
  logic [TW-1:0] tmo;
  logic l_w, alu_l, alu_skip, resp, tmo_hit;
  assign op = ir[DW-1:DW-3];
  assign ea_dir = ir[DW-5] ? {pc_w[AW-1:DW-5], ir[DW-6:0]} : AW'(ir[DW-6:0]);
  assign pc_fin = op == OP_JMP ? ea : pc_w;
  assign tad_sum = {1'b0, ac_w} + {1'b0, wdata};
  assign stall = st != S_READY;
  assign exec_rd_req = st == S_IND_RD || st == S_OPR_RD;
  assign exec_wr_req = st == S_IND_WB || st == S_WR_WAIT;
  assign exec_rd_addr = ea;
  assign exec_wr_addr = ea;
  assign exec_wr_data = wdata;
  assign resp = (exec_rd_req & exec_rd_valid) | (exec_wr_req & exec_wr_ack);
  assign tmo_hit = (exec_rd_req | exec_wr_req) & ~resp & (tmo == TW'(MEM_TIMEOUT - 1));
`ifdef PDP8_AUTOINC_EN
  logic auto_rng;
  assign auto_rng = ea[AW-1:3] == (AW-3)'(1);
`endif
  pdp8_opr_alu #(.DW(DW)) u_alu (
    .ac(ac_w), .l(l_w), .mb(ir[7:0]), .sr(sr), .step(st[1:0]), .g2(st == S_G2),
    .ac_nxt(alu_ac), .l_nxt(alu_l), .skip(alu_skip)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st <= S_IDLE;
      pc_w <= '0;
      PC_value <= '0;
      ac_w <= '0;
      acc <= '0;
      l_w <= 1'b0;
      link <= 1'b0;
      halted <= 1'b0;
      mem_err <= 1'b0;
      tmo <= '0;
      ir <= '0;
      ea <= '0;
      wdata <= '0;
    end else begin
      tmo <= ((exec_rd_req | exec_wr_req) & ~resp) ? tmo + TW'(1) : '0;
      if (tmo_hit) begin
        mem_err <= 1'b1;
        st <= S_HALT;
      end else case (st)
        S_IDLE: begin
          pc_w <= base_addr;
          PC_value <= base_addr;
          st <= S_READY;
        end
        S_READY: if (instr_valid) begin
          ir <= instr;
          st <= S_DECODE;
        end
        S_DECODE: begin
          pc_w <= pc_w + AW'(1);
          ea <= ea_dir;
          st <= op == OP_OPR ? (ir[DW-4] ? S_G2 : S_G1_S1) : op == OP_IOT ? S_DONE :
                ir[DW-4] ? S_IND_RD : route(op);
        end
        S_IND_RD: if (exec_rd_valid) begin
`ifdef PDP8_AUTOINC_EN
          wdata <= exec_rd_data + DW'(1);
          ea <= auto_rng ? ea : AW'(exec_rd_data);
          st <= auto_rng ? S_IND_WB : route(op);
`else
          ea <= AW'(exec_rd_data);
          st <= route(op);
`endif
        end
`ifdef PDP8_AUTOINC_EN
        S_IND_WB: if (exec_wr_ack) begin
          ea <= AW'(wdata);
          st <= route(op);
        end
`endif
        S_OPR_RD: if (exec_rd_valid) begin
          wdata <= exec_rd_data;
          st <= S_EXEC;
        end
        S_EXEC: begin
          ac_w <= op == OP_AND ? ac_w & wdata : op == OP_TAD ? tad_sum[DW-1:0] : ac_w;
          l_w <= op == OP_TAD ? l_w ^ tad_sum[DW] : l_w;
          wdata <= wdata + DW'(1);
          st <= op == OP_ISZ ? S_WR_WAIT : S_DONE;
        end
        // pc_w already points past the JMS, so it is the return address
        S_WR_REQ: begin
          wdata <= op == OP_DCA ? ac_w : DW'(pc_w);
          st <= S_WR_WAIT;
        end
        S_WR_WAIT: if (exec_wr_ack) begin
          ac_w <= op == OP_DCA ? '0 : ac_w;
          pc_w <= op == OP_JMS ? ea + AW'(1) : (op == OP_ISZ && wdata == '0) ? pc_w + AW'(1) : pc_w;
          st <= S_DONE;
        end
        S_G1_S1, S_G1_S2, S_G1_S3, S_G1_S4: begin
          ac_w <= alu_ac;
          l_w <= alu_l;
          st <= st == S_G1_S4 ? S_DONE : st + 4'd1;
        end
        S_G2: begin
          ac_w <= alu_ac;
          pc_w <= pc_w + AW'(alu_skip);
          halted <= halted | ir[B_HLT];
          st <= ir[B_HLT] ? S_HALT : S_DONE;
        end
        S_DONE: begin
          PC_value <= pc_fin;
          pc_w <= pc_fin;
          acc <= ac_w;
          link <= l_w;
          st <= S_READY;
        end
        default: st <= st;
      endcase
    end
  end
endmodule

// File: tb/tb_pdp8_exec_unit_p.sv
// tb_pdp8_exec_unit_p: directed PDP-8 programs plus random instruction stream against a behavioural model
module tb_pdp8_exec_unit_p;
`ifdef PDP8_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, instr_valid = 1'b0;
  logic [11:0] base_addr = '0, instr = '0, sr = '0, exec_rd_data = '0;
  logic exec_rd_valid = 1'b0, exec_wr_ack = 1'b0;
  logic stall, link, halted, mem_err, exec_rd_req, exec_wr_req;
  logic [11:0] PC_value, acc, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic [11:0] mem [4096];
  int mm [4096];
  int m_pc = 0, m_ac = 0, m_l = 0, m_halt = 0;
  int tests = 0, fails = 0;
  bit withhold = 1'b0;
  always #5 clk = ~clk;
  pdp8_exec_unit_p dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr), .instr_valid(instr_valid), .instr(instr), .sr(sr),
    .stall(stall), .PC_value(PC_value), .acc(acc), .link(link), .halted(halted), .mem_err(mem_err),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_valid(exec_rd_valid),
    .exec_rd_data(exec_rd_data), .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_ack(exec_wr_ack)
  );
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0o want %0o", nm, got, exp);
    end
  endtask
  // memory with random latency; also throws stray valid/ack pulses while nothing is requested
  always @(negedge clk) begin
    exec_rd_valid = 1'b0;
    exec_wr_ack = 1'b0;
    exec_rd_data = 12'($urandom);
    if (!withhold) begin
      if (exec_rd_req && $urandom_range(0, 2) == 0) begin
        exec_rd_valid = 1'b1;
        exec_rd_data = mem[exec_rd_addr];
      end else if (!exec_rd_req && $urandom_range(0, 7) == 0) exec_rd_valid = 1'b1;
      if (exec_wr_req && $urandom_range(0, 2) == 0) begin
        exec_wr_ack = 1'b1;
        mem[exec_wr_addr] = exec_wr_data;
      end else if (!exec_wr_req && $urandom_range(0, 7) == 0) exec_wr_ack = 1'b1;
    end
  end
  // committed architectural state must match the model whenever the unit is ready
  always @(negedge clk) begin
    if (reset_n && !stall) begin
      chk("pc", int'(PC_value), m_pc);
      chk("acc", int'(acc), m_ac);
      chk("link", int'(link), m_l);
      chk("halted", int'(halted), m_halt);
      chk("mem_err", int'(mem_err), 0);
    end
  end
  task automatic model_exec(input logic [11:0] w);
    int op, ea, s, v, pc1;
    bit skip;
    op = int'(w[11:9]);
    pc1 = (m_pc + 1) % 4096;
    if (op < 6) begin
      ea = w[7] ? ((m_pc & 'o7600) | int'(w[6:0])) : int'(w[6:0]);
      if (w[8]) begin
        if (AUTOINC && ea >= 'o10 && ea <= 'o17) mm[ea] = (mm[ea] + 1) % 4096;
        ea = mm[ea];
      end
      case (op)
        0: m_ac = m_ac & mm[ea];
        1: begin
          s = m_ac + mm[ea];
          if (s > 'o7777) m_l ^= 1;
          m_ac = s % 4096;
        end
        2: begin
          mm[ea] = (mm[ea] + 1) % 4096;
          if (mm[ea] == 0) pc1 = (pc1 + 1) % 4096;
        end
        3: begin
          mm[ea] = m_ac;
          m_ac = 0;
        end
        4: begin
          mm[ea] = pc1;
          pc1 = (ea + 1) % 4096;
        end
        default: pc1 = ea;
      endcase
    end else if (op == 7 && !w[8]) begin
      if (w[7]) m_ac = 0;
      if (w[6]) m_l = 0;
      if (w[5]) m_ac = 'o7777 - m_ac;
      if (w[4]) m_l ^= 1;
      if (w[0]) begin
        m_ac = m_ac + 1;
        if (m_ac == 4096) begin
          m_ac = 0;
          m_l ^= 1;
        end
      end
      v = m_l * 4096 + m_ac;
      for (int k = 0; k < (w[1] ? 2 : 1); k++) begin
        if (w[3]) v = (v / 2) + (v % 2) * 4096;
        else if (w[2]) v = (v * 2) % 8192 + v / 4096;
      end
      m_l = v / 4096;
      m_ac = v % 4096;
    end else if (op == 7) begin
      skip = (w[6] && m_ac >= 'o4000) || (w[5] && m_ac == 0) || (w[4] && m_l == 1);
      if (w[3]) skip = !skip;
      if (skip) pc1 = (pc1 + 1) % 4096;
      if (w[7]) m_ac = 0;
      if (w[2]) m_ac = m_ac | int'(sr);
      if (w[1]) m_halt = 1;
    end
    m_pc = pc1;
  endtask
  task automatic setm(input int a, input int d);
    mem[a] = 12'(d);
    mm[a] = d;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (stall && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (stall) chk("ready_timeout", 1, 0);
  endtask
  task automatic issue(input logic [11:0] w);
    int bad = -1;
    wait_ready();
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    model_exec(w);
    if (!m_halt) wait_ready();
    for (int a = 0; a < 4096; a++) if (int'(mem[a]) != mm[a]) bad = a;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL memory mem[%0o]=%0o want %0o after instr %0o", bad, mem[bad], mm[bad], w);
    end
  endtask
  task automatic do_reset(input logic [11:0] base);
    reset_n = 1'b0;
    instr_valid = 1'b0;
    withhold = 1'b0;
    base_addr = base;
    repeat (3) @(negedge clk);
    chk("rst_stall", int'(stall), 1);
    chk("rst_pc", int'(PC_value), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_link", int'(link), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_mem_err", int'(mem_err), 0);
    chk("rst_rd_req", int'(exec_rd_req), 0);
    chk("rst_wr_req", int'(exec_wr_req), 0);
    m_pc = int'(base);
    m_ac = 0;
    m_l = 0;
    m_halt = 0;
    reset_n = 1'b1;
  endtask
  initial begin
    logic [11:0] w;
    for (int a = 0; a < 4096; a++) setm(a, int'($urandom_range(0, 4095)));
    @(negedge clk);
    do_reset(12'o0200);
    issue(12'o7040);
    issue(12'o5200);
    setm('o210, 'o0001);
    issue(12'o1210);
    chk("tad_acc", int'(acc), 'o0000);
    chk("tad_link", int'(link), 1);
    chk("tad_pc", int'(PC_value), 'o0201);
    setm('o220, 'o7777);
    setm('o221, 'o0005);
    issue(12'o2220);
    chk("isz_wrap_mem", int'(mem['o220]), 'o0000);
    chk("isz_wrap_pc", int'(PC_value), 'o0203);
    issue(12'o2221);
    chk("isz_mem", int'(mem['o221]), 'o0006);
    chk("isz_pc", int'(PC_value), 'o0204);
    issue(12'o5200);
    issue(12'o4300);
    chk("jms_mem", int'(mem['o300]), 'o0201);
    chk("jms_pc", int'(PC_value), 'o0301);
    issue(12'o5700);
    chk("jmp_ind_pc", int'(PC_value), 'o0201);
    issue(12'o7200);
    repeat (3) issue(12'o7001);
    issue(12'o7041);
    chk("cia_acc", int'(acc), 'o7775);
    sr = 12'o4000;
    issue(12'o7604);
    sr = 12'o0000;
    chk("osr_acc", int'(acc), 'o4000);
    issue(12'o7510);
    chk("spa_noskip_pc", int'(PC_value), 'o0210);
    issue(12'o7500);
    chk("sma_skip_pc", int'(PC_value), 'o0212);
    issue(12'o7402);
    repeat (5) @(negedge clk);
    chk("hlt_halted", int'(halted), 1);
    chk("hlt_stall", int'(stall), 1);
    do_reset(12'o0200);
    wait_ready();
    withhold = 1'b1;
    instr = 12'o1210;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("tmo_mem_err", int'(mem_err), 1);
    chk("tmo_rd_req", int'(exec_rd_req), 0);
    chk("tmo_stall", int'(stall), 1);
    do_reset(12'o0200);
    setm('o10, 'o0377);
    setm('o400, 'o0002);
    setm('o377, 'o0005);
    issue(12'o1410);
    chk("autoinc_acc", int'(acc), AUTOINC ? 'o0002 : 'o0005);
    chk("autoinc_ptr", int'(mem['o10]), AUTOINC ? 'o0400 : 'o0377);
    for (int k = 0; k < 400; k++) begin
      w = 12'($urandom);
      if (w[11:9] == 3'd7 && w[8]) w[1] = 1'b0;
      if (w[11:9] == 3'd7 && !w[8] && w[3]) w[2] = 1'b0;
      sr = 12'($urandom);
      issue(w);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
